stopwatch_bcd_core: RTL and testbench

- Upstream producer of the 32-bit packed-hex word consumed by the 8-digit scanning display mux, which selects 4-bit digits by anode index.
- Implements an M:SS.T stopwatch/countdown in BCD, with start/stop, clear/preset and lap capture.
- Takes raw, bouncy buttons: each button is synchronised, debounced and edge-detected inside this block.
- The display mux needs no changes.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/btn_debounce_pulse.sv | 41 ++++
 rtl/stopwatch_bcd_core.sv | 148 ++++++++++++++
 tb/tb_stopwatch_bcd_core.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared digit widths, digit limits, field offsets and the packed BCD time word
// for the M:SS.T stopwatch.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam int TIME_W  = 4 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] MAX_TENTHS   = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_SEC_ONES = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;
    localparam logic [DIGIT_W-1:0] MAX_MIN      = 4'd9;

    localparam int TENTHS_LSB   = 0;
    localparam int SEC_ONES_LSB = 4;
    localparam int SEC_TENS_LSB = 8;
    localparam int MIN_LSB      = 12;

    typedef struct packed {
        logic [DIGIT_W-1:0] min;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
        logic [DIGIT_W-1:0] tenths;
    } sw_time_t;

    localparam sw_time_t TIME_ZERO = '0;
    localparam sw_time_t TIME_MAX  = '{min: MAX_MIN, sec_tens: MAX_SEC_TENS,
                                       sec_ones: MAX_SEC_ONES, tenths: MAX_TENTHS};

endpackage

// File: rtl/btn_debounce_pulse.sv
// Raw button conditioning: 2-FF synchroniser, saturating debounce counter and a
// single-cycle pulse when the level has been stable high for DEBOUNCE_CYCLES.
module btn_debounce_pulse
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Saturation at CNT_MAX means a held button fires once and must go low to re-arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            pulse  <= 1'b0;
            if (!sync_2) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt   <= cnt + 1'b1;
                pulse <= (cnt == CNT_MAX - 1'b1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_bcd_core.sv
// M:SS.T BCD stopwatch / countdown with start/stop, clear/preset and lap capture.
// Drives the packed {lap, live} word consumed by the 8-digit display mux.
module stopwatch_bcd_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 10000000,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start,
    input  logic              btn_clear,
    input  logic              btn_lap,
    input  logic              dir,
    input  logic [TIME_W-1:0] preset_bcd,
    output logic [31:0]       disp_data,
    output logic              running,
    output logic              done,
    output logic              wrap
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] max);
        return (d > max) ? max : d;
    endfunction

    function automatic sw_time_t clamp_time(input logic [TIME_W-1:0] raw);
        sw_time_t t;
        t.min      = sat_digit(raw[MIN_LSB      +: DIGIT_W], MAX_MIN);
        t.sec_tens = sat_digit(raw[SEC_TENS_LSB +: DIGIT_W], MAX_SEC_TENS);
        t.sec_ones = sat_digit(raw[SEC_ONES_LSB +: DIGIT_W], MAX_SEC_ONES);
        t.tenths   = sat_digit(raw[TENTHS_LSB   +: DIGIT_W], MAX_TENTHS);
        return t;
    endfunction

    function automatic sw_time_t bcd_inc(input sw_time_t t);
        sw_time_t r = t;
        if (t.tenths != MAX_TENTHS) begin
            r.tenths = t.tenths + 4'd1;
        end else begin
            r.tenths = '0;
            if (t.sec_ones != MAX_SEC_ONES) begin
                r.sec_ones = t.sec_ones + 4'd1;
            end else begin
                r.sec_ones = '0;
                if (t.sec_tens != MAX_SEC_TENS) begin
                    r.sec_tens = t.sec_tens + 4'd1;
                end else begin
                    r.sec_tens = '0;
                    r.min      = (t.min != MAX_MIN) ? t.min + 4'd1 : '0;
                end
            end
        end
        return r;
    endfunction

    function automatic sw_time_t bcd_dec(input sw_time_t t);
        sw_time_t r = t;
        if (t.tenths != '0) begin
            r.tenths = t.tenths - 4'd1;
        end else begin
            r.tenths = MAX_TENTHS;
            if (t.sec_ones != '0) begin
                r.sec_ones = t.sec_ones - 4'd1;
            end else begin
                r.sec_ones = MAX_SEC_ONES;
                if (t.sec_tens != '0) begin
                    r.sec_tens = t.sec_tens - 4'd1;
                end else begin
                    r.sec_tens = MAX_SEC_TENS;
                    r.min      = (t.min != '0) ? t.min - 4'd1 : MAX_MIN;
                end
            end
        end
        return r;
    endfunction

    logic             start_pulse;
    logic             clear_pulse;
    logic             lap_pulse;
    logic [PRE_W-1:0] prescaler;
    logic             tick;
    sw_time_t         live;
    sw_time_t         lap;

    btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .rst(rst), .btn(btn_start), .pulse(start_pulse)
    );
    btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .rst(rst), .btn(btn_clear), .pulse(clear_pulse)
    );
    btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk(clk), .rst(rst), .btn(btn_lap), .pulse(lap_pulse)
    );

    assign tick      = running && (prescaler == PRE_LAST);
    assign disp_data = {lap, live};

    // Clear overrides start and tick; lap always samples the pre-edge live value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live      <= TIME_ZERO;
            lap       <= TIME_ZERO;
            running   <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            prescaler <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            if (lap_pulse) begin
                lap <= live;
            end
            if (clear_pulse) begin
                running   <= 1'b0;
                prescaler <= '0;
                live      <= dir ? clamp_time(preset_bcd) : TIME_ZERO;
            end else begin
                if (running) begin
                    prescaler <= tick ? '0 : prescaler + 1'b1;
                end
                if (start_pulse) begin
                    if (running) begin
                        running <= 1'b0;
                    end else if (!(dir && live == TIME_ZERO)) begin
                        running <= 1'b1;
                    end
                end
                // A countdown already at zero stops on the following tick, not on arrival.
                if (tick) begin
                    if (!dir) begin
                        live <= bcd_inc(live);
                        wrap <= (live == TIME_MAX);
                    end else if (live == TIME_ZERO) begin
                        done    <= 1'b1;
                        running <= 1'b0;
                    end else begin
                        live <= bcd_dec(live);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Directed bench for stopwatch_bcd_core with a short tick (4 clocks) and a
// 3-cycle debounce so full count sequences fit in a few hundred clocks.
module tb_stopwatch_bcd_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start;
    logic        btn_clear;
    logic        btn_lap;
    logic        dir;
    logic [15:0] preset_bcd;
    logic [31:0] disp_data;
    logic        running;
    logic        done;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    stopwatch_bcd_core #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_lap(btn_lap), .dir(dir), .preset_bcd(preset_bcd),
        .disp_data(disp_data), .running(running), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the selected buttons just long enough for their pulse to take effect.
    task automatic press(input logic s, input logic c, input logic l);
        btn_start = s;
        btn_clear = c;
        btn_lap   = l;
        step(6);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        dir = 1'b0; preset_bcd = 16'h0000;
        step(3);
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL reset_disp got %h want %h", disp_data, 32'h0); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
        rst = 1'b0;
        step(2);
        checks++; if (disp_data !== 32'h0 || running !== 1'b0) begin errors++; $display("FAIL post_reset got %h/%b want 0/0", disp_data, running); end
    endtask

    task automatic test_start_debounce;
        btn_start = 1'b1;
        step(6);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b want 1", running); end
        checks++; if (disp_data[15:0] !== 16'h0000) begin errors++; $display("FAIL start_live0 got %h want 0000", disp_data[15:0]); end
        step(4);
        btn_start = 1'b0;
        checks++; if (disp_data[15:0] !== 16'h0001) begin errors++; $display("FAIL first_tick got %h want 0001", disp_data[15:0]); end
        step(35);
        checks++; if (disp_data[15:0] !== 16'h0009) begin errors++; $display("FAIL tick9 got %h want 0009", disp_data[15:0]); end
        step(1);
        checks++; if (disp_data[15:0] !== 16'h0010) begin errors++; $display("FAIL tick10 got %h want 0010", disp_data[15:0]); end
        btn_start = 1'b1;
        step(2);
        btn_start = 1'b0;
        step(6);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL glitch_running got %b want 1", running); end
        checks++; if (disp_data[15:0] !== 16'h0012) begin errors++; $display("FAIL glitch_live got %h want 0012", disp_data[15:0]); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running got %b want 0", running); end
        step(4);
    endtask

    task automatic test_wrap;
        dir = 1'b1; preset_bcd = 16'h9598;
        press(1'b0, 1'b1, 1'b0);
        checks++; if (disp_data[15:0] !== 16'h9598 || running !== 1'b0) begin errors++; $display("FAIL wrap_preset got %h/%b want 9598/0", disp_data[15:0], running); end
        step(4);
        dir = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL wrap_start got %b want 1", running); end
        step(3);
        checks++; if (disp_data[15:0] !== 16'h9598) begin errors++; $display("FAIL wrap_hold got %h want 9598", disp_data[15:0]); end
        step(1);
        checks++; if (disp_data[15:0] !== 16'h9599 || wrap !== 1'b0) begin errors++; $display("FAIL wrap_9599 got %h/%b want 9599/0", disp_data[15:0], wrap); end
        step(4);
        checks++; if (disp_data[15:0] !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", disp_data[15:0]); end
        checks++; if (wrap !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL wrap_pulse got wrap=%b run=%b want 1/1", wrap, running); end
        step(1);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_oneshot got %b want 0", wrap); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL wrap_stop got %b want 0", running); end
        step(4);
    endtask

    task automatic test_countdown;
        dir = 1'b1; preset_bcd = 16'h0002;
        press(1'b0, 1'b1, 1'b0);
        checks++; if (disp_data[15:0] !== 16'h0002) begin errors++; $display("FAIL cd_preset got %h want 0002", disp_data[15:0]); end
        step(4);
        press(1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL cd_start got %b want 1", running); end
        step(4);
        checks++; if (disp_data[15:0] !== 16'h0001) begin errors++; $display("FAIL cd_0001 got %h want 0001", disp_data[15:0]); end
        step(4);
        checks++; if (disp_data[15:0] !== 16'h0000 || running !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL cd_reach0 got %h/run=%b/done=%b want 0000/1/0", disp_data[15:0], running, done); end
        step(4);
        checks++; if (done !== 1'b1 || running !== 1'b0 || disp_data[15:0] !== 16'h0000) begin errors++; $display("FAIL cd_done got done=%b run=%b live=%h want 1/0/0000", done, running, disp_data[15:0]); end
        step(1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cd_done_oneshot got %b want 0", done); end
        step(4);
        press(1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b0 || disp_data[15:0] !== 16'h0000) begin errors++; $display("FAIL cd_start_at_zero got run=%b live=%h want 0/0000", running, disp_data[15:0]); end
        step(4);
    endtask

    task automatic test_clamp;
        dir = 1'b1; preset_bcd = 16'hA7BC;
        press(1'b0, 1'b1, 1'b0);
        checks++; if (disp_data[15:0] !== 16'h9599) begin errors++; $display("FAIL clamp got %h want 9599", disp_data[15:0]); end
        step(4);
    endtask

    task automatic test_lap;
        dir = 1'b1; preset_bcd = 16'h0122;
        press(1'b0, 1'b1, 1'b0);
        step(4);
        dir = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        btn_lap = 1'b1;
        step(6);
        btn_lap = 1'b0;
        checks++; if (disp_data !== {16'h0123, 16'h0123}) begin errors++; $display("FAIL lap_capture got %h want 01230123", disp_data); end
        step(2);
        checks++; if (disp_data !== {16'h0123, 16'h0124}) begin errors++; $display("FAIL lap_hold got %h want 01230124", disp_data); end
        press(1'b1, 1'b1, 1'b0);
        checks++; if (disp_data !== {16'h0123, 16'h0000} || running !== 1'b0) begin errors++; $display("FAIL clear_start got %h/%b want 01230000/0", disp_data, running); end
        step(8);
        checks++; if (running !== 1'b0 || disp_data[15:0] !== 16'h0000) begin errors++; $display("FAIL clear_start_idle got %b/%h want 0/0000", running, disp_data[15:0]); end
        dir = 1'b1; preset_bcd = 16'h0456;
        press(1'b0, 1'b1, 1'b0);
        checks++; if (disp_data !== {16'h0123, 16'h0456}) begin errors++; $display("FAIL clear_keeps_lap got %h want 01230456", disp_data); end
        step(4);
        dir = 1'b0;
        press(1'b0, 1'b1, 1'b1);
        checks++; if (disp_data !== {16'h0456, 16'h0000}) begin errors++; $display("FAIL lap_clear got %h want 04560000", disp_data); end
        step(4);
    endtask

    task automatic test_async_reset;
        dir = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        step(10);
        checks++; if (running !== 1'b1 || disp_data[15:0] !== 16'h0002) begin errors++; $display("FAIL pre_reset got run=%b live=%h want 1/0002", running, disp_data[15:0]); end
        btn_start = 1'b1;
        step(2);
        #2 rst = 1'b1;
        #1;
        checks++; if (disp_data !== 32'h0 || running !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL async_reset got disp=%h run=%b done=%b wrap=%b want 0", disp_data, running, done, wrap); end
        btn_start = 1'b0;
        step(2);
        rst = 1'b0;
        step(10);
        checks++; if (running !== 1'b0 || disp_data !== 32'h0) begin errors++; $display("FAIL no_stale_pulse got run=%b disp=%h want 0/0", running, disp_data); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL new_press got %b want 1", running); end
    endtask

    initial begin
        test_reset;
        test_start_debounce;
        test_wrap;
        test_countdown;
        test_clamp;
        test_lap;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
